req_encoder_rr: RTL and testbench

- Parametrised, registered N-to-log2(N) request encoder.
- Successor to the fixed 8-to-3 one-hot encoder. Handles any number of set bits using fixed-priority or round-robin selection.
- Flags zero-hot and multi-hot inputs.
- Valid/ready on both sides. Sits between request sources (interrupt lines, channel requests) and a single downstream consumer.

---
 rtl/req_encoder_rr_pkg.sv | 18 +
 rtl/req_encoder_rr_prio_pick.sv | 42 ++++
 rtl/req_encoder_rr.sv | 80 ++++++++
 tb/tb_req_encoder_rr.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/req_encoder_rr_pkg.sv
// Shared constants and helpers for the request encoder family.
// Selection-mode codes, index-width rule and multi-hot detection.
package enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Width of an index into n lines, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // True when at least two bits are set: clearing the lowest set bit leaves something.
    function automatic logic multi_hot(input logic [63:0] v);
        return (v & (v - 64'd1)) != 64'd0;
    endfunction

endpackage

// File: rtl/req_encoder_rr_prio_pick.sv
// Combinational circular priority picker: first set bit of req at or after start.
// The vector is doubled so the wrap-around search becomes a plain lowest-bit search.
module prio_pick
    import enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    localparam int PW = idx_w(2 * N);

    logic [N-1:0]   hi_mask;
    logic [2*N-1:0] dbl;
    logic [PW-1:0]  pos;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign hi_mask[gi] = (W'(gi) >= start);
        end
    endgenerate

    // Lower copy keeps only bits at/after start; upper copy supplies the wrapped ones.
    assign dbl = {req, req & hi_mask};

    always_comb begin
        pos = '0;
        for (int i = 2 * N - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                pos = PW'(i);
            end
        end
    end

    assign idx   = (pos >= PW'(N)) ? W'(pos - PW'(N)) : W'(pos);
    assign found = |req;

endmodule

// File: rtl/req_encoder_rr.sv
// Registered N-to-log2(N) request encoder with fixed-priority or round-robin pick,
// zero-hot / multi-hot flags and valid/ready handshakes on both sides.
module req_encoder_rr
    import enc_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int RR_EN = MODE_FIXED,
    localparam int W     = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_none,
    output logic         out_multi
);

    logic         rdy_en_reg;
    logic         out_valid_reg;
    logic [W-1:0] out_idx_reg;
    logic         out_none_reg;
    logic         out_multi_reg;
    logic [W-1:0] ptr_reg;
    logic [W-1:0] ptr_next;

    logic [W-1:0] start;
    logic [W-1:0] pick_idx;
    logic         pick_found;
    logic         accept;

    // Fixed priority is the round-robin search pinned to start at line 0.
    assign start = (RR_EN == MODE_RR) ? ptr_reg : '0;

    prio_pick #(.N(N)) u_pick (
        .req   (in_req),
        .start (start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign ptr_next = (pick_idx == W'(N - 1)) ? '0 : pick_idx + W'(1);

    // rdy_en_reg holds in_ready low for the first cycle after reset release.
    assign in_ready = rdy_en_reg && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
            out_none_reg  <= 1'b0;
            out_multi_reg <= 1'b0;
            ptr_reg       <= '0;
        end else begin
            rdy_en_reg <= 1'b1;
            if (accept) begin
                out_valid_reg <= 1'b1;
                out_idx_reg   <= pick_found ? pick_idx : '0;
                out_none_reg  <= !pick_found;
                out_multi_reg <= multi_hot(64'(in_req));
                if ((RR_EN == MODE_RR) && pick_found) begin
                    ptr_reg <= ptr_next;
                end
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_idx   = out_idx_reg;
    assign out_none  = out_none_reg;
    assign out_multi = out_multi_reg;

endmodule

// File: tb/tb_req_encoder_rr.sv
// Bench for req_encoder_rr: directed N=8 scenarios plus a randomized sweep over
// several sizes, with a queue scoreboard fed by a specification-level model.
module tb_req_encoder_rr;
    import enc_pkg::*;

    localparam int NCFG = 5;

    function automatic int cfg_n(input int k);
        case (k)
            0: return 8;
            1: return 8;
            2: return 2;
            3: return 5;
            default: return 64;
        endcase
    endfunction

    function automatic int cfg_rr(input int k);
        return (k == 0) ? MODE_FIXED : MODE_RR;
    endfunction

    logic        clk;
    logic        rst_n;
    logic        iv    [NCFG];
    logic        irdy  [NCFG];
    logic [63:0] req_a [NCFG];
    logic        ov    [NCFG];
    logic        ordy  [NCFG];
    logic [6:0]  oidx  [NCFG];
    logic        onone [NCFG];
    logic        omulti[NCFG];

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q [NCFG][$];
    int         mptr  [NCFG];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
            localparam int NN = cfg_n(gi);
            localparam int WW = idx_w(NN);
            logic [NN-1:0] r;
            logic [WW-1:0] ix;
            assign r = req_a[gi][NN-1:0];
            req_encoder_rr #(.N(NN), .RR_EN(cfg_rr(gi))) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (iv[gi]),
                .in_ready  (irdy[gi]),
                .in_req    (r),
                .out_valid (ov[gi]),
                .out_ready (ordy[gi]),
                .out_idx   (ix),
                .out_none  (onone[gi]),
                .out_multi (omulti[gi])
            );
            assign oidx[gi] = 7'(ix);
        end
    endgenerate

    // Reference pick: walk the lines in priority order from start, first hit wins.
    function automatic int ref_pick(input logic [63:0] r, input int n, input int s);
        for (int k = 0; k < n; k++) begin
            int i;
            i = (s + k) % n;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req_v);
        end
    endtask

    // Scoreboard: accepts push the model's answer, deliveries pop and compare.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < NCFG; d++) begin
                if (ov[d] && ordy[d]) begin
                    checks++;
                    if (exp_q[d].size() == 0) begin
                        failures++;
                        $display("FAIL sb_dut%0d unexpected delivery idx=%0d", d, oidx[d]);
                    end else begin
                        logic [8:0] e;
                        e = exp_q[d].pop_front();
                        if ({oidx[d], onone[d], omulti[d]} !== e) begin
                            failures++;
                            $display("FAIL sb_dut%0d actual idx=%0d none=%0b multi=%0b required idx=%0d none=%0b multi=%0b",
                                     d, oidx[d], onone[d], omulti[d], e[8:2], e[1], e[0]);
                        end
                    end
                end
                if (iv[d] && irdy[d]) begin
                    int n, k;
                    logic [63:0] rm;
                    n  = cfg_n(d);
                    rm = (n == 64) ? req_a[d] : (req_a[d] & ((64'd1 << n) - 64'd1));
                    k  = ref_pick(rm, n, (cfg_rr(d) == MODE_RR) ? mptr[d] : 0);
                    if (k < 0) begin
                        exp_q[d].push_back({7'd0, 1'b1, 1'b0});
                    end else begin
                        exp_q[d].push_back({7'(k), 1'b0, ($countones(rm) > 1)});
                        if (cfg_rr(d) == MODE_RR) mptr[d] = (k + 1) % n;
                    end
                end
            end
        end
    end

    task automatic clear_model();
        for (int d = 0; d < NCFG; d++) begin
            exp_q[d].delete();
            mptr[d] = 0;
        end
    endtask

    // Offer one vector (inputs change at posedge+1), then check it one cycle later.
    task automatic send(input int d, input logic [63:0] r, input int ei,
                        input logic en, input logic em, input string nm);
        iv[d]    = 1'b1;
        req_a[d] = r;
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
        chk({nm, "_idx"}, 64'(oidx[d]), 64'(ei));
        chk({nm, "_vld_none_multi"}, {61'd0, ov[d], onone[d], omulti[d]}, {61'd0, 1'b1, en, em});
    endtask

    function automatic logic [63:0] gen_req(input int d);
        int n;
        logic [63:0] m;
        n = cfg_n(d);
        m = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        case ($urandom % 4)
            0:       return 64'd0;
            1:       return 64'd1 << ($urandom % n);
            default: return {$urandom, $urandom} & m;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < NCFG; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1; req_a[d] = '0;
        end
        clear_model();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {58'd0, ov[0], oidx[0], onone[0], omulti[0], irdy[0]}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", 64'(irdy[0]), 64'd1);

        for (int i = 0; i < 8; i++) send(0, 64'd1 << i, i, 1'b0, 1'b0, "onehot_sweep");
        send(0, 64'hA4, 2, 1'b0, 1'b1, "fixed_multi");
        send(0, 64'h00, 0, 1'b1, 1'b0, "fixed_zero");

        send(1, 64'h85, 0, 1'b0, 1'b1, "rr_pick0");
        send(1, 64'h85, 2, 1'b0, 1'b1, "rr_pick1");
        send(1, 64'h00, 0, 1'b1, 1'b0, "rr_zero");
        send(1, 64'h85, 7, 1'b0, 1'b1, "rr_pick2");
        send(1, 64'h85, 0, 1'b0, 1'b1, "rr_pick3");
        @(posedge clk);
        #1;

        // Backpressure: result 5 must hold while a competing vector is refused.
        send(0, 64'h20, 5, 1'b0, 1'b0, "bp_load");
        ordy[0] = 1'b0; iv[0] = 1'b1; req_a[0] = 64'h01;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_idx", 64'(oidx[0]), 64'd5);
            chk("bp_in_ready", {62'd0, irdy[0], ov[0]}, 64'b01);
        end
        ordy[0] = 1'b1;
        send(0, 64'h08, 3, 1'b0, 1'b0, "bp_drain_accept");
        @(posedge clk);
        #1;
        chk("drain_only", {57'd0, ov[0], oidx[0]}, 64'd3);

        // Round-robin pointer at 6 with a stalled result, then reset between edges.
        send(1, 64'h20, 5, 1'b0, 1'b0, "rr_ptr6");
        ordy[1] = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {58'd0, ov[1], oidx[1], onone[1], omulti[1], irdy[1]}, 64'd0);
        clear_model();
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        ordy[1] = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_in_ready", 64'(irdy[1]), 64'd1);
        send(1, 64'hFF, 0, 1'b0, 1'b1, "post_reset_ff");

        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < NCFG; d++) begin
                iv[d]    = ($urandom % 4) != 0;
                ordy[d]  = ($urandom % 3) != 0;
                req_a[d] = gen_req(d);
            end
            @(posedge clk);
            #1;
        end
        for (int d = 0; d < NCFG; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NCFG; d++) chk($sformatf("sb_empty_dut%0d", d), 64'(exp_q[d].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
